// File: rtl/weight_bank_dbuf.sv
// Double-buffered weight bank: weights load into a shadow bank by addressed writes
// or an auto-incrementing burst, and reach the active bank only on commit.
//
// Burst handshake: a word transfers on a rising edge where burstValid && burstReady.
// burstReady is high for the whole BURST state; burstValid low stalls with no change.
module weight_bank_dbuf #(
  parameter int DATA_W    = 8,
  parameter int N_WEIGHTS = 10,
  parameter int ADDR_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           dataIn,
  input  logic [ADDR_W-1:0]           address,
  input  logic                        write,
  input  logic                        burstStart,
  input  logic                        burstValid,
  output logic                        burstReady,
  output logic                        burstDone,
  input  logic                        commit,
  input  logic [ADDR_W-1:0]           rdAddr,
  output logic [DATA_W-1:0]           rdData,
  output logic [N_WEIGHTS*DATA_W-1:0] weightsOut,
  output logic                        busy,
  output logic                        addrErr,
  output logic [1:0]                  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   NW   = (ADDR_W+1)'(N_WEIGHTS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WEIGHTS - 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] shadow [N_WEIGHTS];
  logic [DATA_W-1:0] active [N_WEIGHTS];
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] cnt;
  logic              pending;

  logic addr_ok, rd_ok;
  logic single_we, burst_we, start, copy_now, pend_set, pend_clr, err_set;

  assign addr_ok   = {1'b0, address} < NW;
  assign rd_ok     = {1'b0, rdAddr} < NW;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    burstReady = 1'b0;
    burstDone  = 1'b0;
    single_we  = 1'b0;
    burst_we   = 1'b0;
    start      = 1'b0;
    copy_now   = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        copy_now = commit;
        // A valid burst start takes priority over a same-cycle single write.
        if (burstStart) begin
          if (addr_ok) begin
            start    = 1'b1;
            state_nx = BURST;
          end else begin
            err_set = 1'b1;
          end
        end else if (write) begin
          if (addr_ok) single_we = 1'b1;
          else         err_set   = 1'b1;
        end
      end
      BURST: begin
        busy       = 1'b1;
        burstReady = 1'b1;
        pend_set   = commit;
        if (burstValid) begin
          burst_we = 1'b1;
          if (cnt == LAST) state_nx = DONE;
        end
      end
      DONE: begin
        burstDone = 1'b1;
        copy_now  = pending | commit;
        pend_clr  = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_WEIGHTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      ptr     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      addrErr <= 1'b0;
      rdData  <= '0;
    end else begin
      if (single_we) shadow[address] <= dataIn;
      if (burst_we) begin
        shadow[ptr] <= dataIn;
        ptr         <= (ptr == LAST) ? '0 : ptr + 1'b1;
        cnt         <= cnt + 1'b1;
      end
      if (start) begin
        ptr <= address;
        cnt <= '0;
      end
      // Copy reads the pre-edge shadow, so a same-edge write is not included.
      if (copy_now) begin
        for (int i = 0; i < N_WEIGHTS; i++) active[i] <= shadow[i];
      end
      if (pend_set)      pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;
      if (err_set) addrErr <= 1'b1;
      rdData <= rd_ok ? shadow[rdAddr] : '0;
    end
  end

  for (genvar g = 0; g < N_WEIGHTS; g++) begin : g_out
    assign weightsOut[g*DATA_W +: DATA_W] = active[g];
  end

endmodule

// File: tb/tb_weight_bank_dbuf.sv
// Directed bench for weight_bank_dbuf: single writes, wrapped/stalled bursts,
// commit timing, out-of-range handling and asynchronous reset mid-burst.
module tb_weight_bank_dbuf;

  localparam int DW = 8;
  localparam int NW = 10;
  localparam int AW = 4;
  localparam int WV = NW * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] dataIn;
  logic [AW-1:0] address;
  logic          write, burstStart, burstValid, commit;
  logic [AW-1:0] rdAddr;
  logic          burstReady, burstDone, busy, addrErr;
  logic [DW-1:0] rdData;
  logic [WV-1:0] weightsOut;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  logic [WV-1:0] exp_sh;
  logic [WV-1:0] exp_act;

  weight_bank_dbuf #(.DATA_W(DW), .N_WEIGHTS(NW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .dataIn(dataIn), .address(address), .write(write),
    .burstStart(burstStart), .burstValid(burstValid), .burstReady(burstReady),
    .burstDone(burstDone), .commit(commit), .rdAddr(rdAddr), .rdData(rdData),
    .weightsOut(weightsOut), .busy(busy), .addrErr(addrErr), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (burstDone) done_cnt++;

  task automatic check(input string tag, input logic [WV-1:0] got, input logic [WV-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_burst(input int a);
    address    = AW'(a);
    burstStart = 1'b1;
    tick();
    burstStart = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] d, input int a);
    burstValid = 1'b1;
    dataIn     = d;
    tick();
    burstValid = 1'b0;
    exp_sh[a*DW +: DW] = d;
  endtask

  task automatic readback_all(input string tag);
    for (int i = 0; i < NW; i++) begin
      rdAddr = AW'(i);
      tick();
      check(tag, WV'(rdData), WV'(exp_sh[i*DW +: DW]));
    end
  endtask

  initial begin
    rst_n = 1'b0; dataIn = '0; address = '0; write = 1'b0; burstStart = 1'b0;
    burstValid = 1'b0; commit = 1'b0; rdAddr = '0;
    exp_sh = '0; exp_act = '0;
    #3;
    check("rst_weights", weightsOut, '0);
    check("rst_busy", WV'(busy), '0);
    check("rst_ready", WV'(burstReady), '0);
    check("rst_done", WV'(burstDone), '0);
    check("rst_err", WV'(addrErr), '0);
    check("rst_rd", WV'(rdData), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // single writes, readback latency, then commit
    rdAddr = 4'd3;
    for (int i = 0; i < NW; i++) begin
      address = AW'(i); dataIn = DW'(i); write = 1'b1;
      tick();
      exp_sh[i*DW +: DW] = DW'(i);
      if (i == 3) check("rd_lat_old", WV'(rdData), '0);
      if (i == 4) check("rd_lat_new", WV'(rdData), WV'(8'd3));
    end
    write = 1'b0;
    check("pre_commit", weightsOut, '0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    exp_act = exp_sh;
    check("commit_single", weightsOut, exp_act);

    // wrapped burst from 7 with a stall before every word
    start_burst(7);
    check("burst_state", WV'(state_dbg), WV'(2'd1));
    for (int k = 0; k < NW; k++) begin
      tick();
      check("stall_busy", WV'({busy, burstReady}), WV'(2'b11));
      send_word(DW'(8'hA0 + k), (7 + k) % NW);
      if (k < NW - 1) check("burst_busy", WV'(busy), WV'(1'b1));
    end
    check("wrap_done", WV'(burstDone), WV'(1'b1));
    check("wrap_done_busy", WV'({busy, burstReady}), '0);
    tick();
    check("wrap_done_once", WV'(burstDone), '0);
    check("wrap_done_cnt", WV'(done_cnt), WV'(1));
    readback_all("wrap_shadow");
    check("wrap_no_commit", weightsOut, exp_act);

    // commit during burst is deferred to the edge leaving DONE
    start_burst(0);
    for (int k = 0; k < NW; k++) begin
      commit = (k == 4);
      send_word(DW'(8'hB0 + k), k);
      commit = 1'b0;
      check("defer_hold", weightsOut, exp_act);
    end
    check("defer_done", WV'(burstDone), WV'(1'b1));
    tick();
    exp_act = exp_sh;
    check("defer_commit", weightsOut, exp_act);
    check("defer_done_cnt", WV'(done_cnt), WV'(2));

    // out-of-range accesses
    check("err_clear", WV'(addrErr), '0);
    address = 4'd12; dataIn = 8'hFF; write = 1'b1;
    tick();
    write = 1'b0;
    check("err_write", WV'(addrErr), WV'(1'b1));
    start_burst(10);
    check("err_no_burst", WV'(busy), '0);
    rdAddr = 4'd15;
    tick();
    check("rd_oob", WV'(rdData), '0);
    readback_all("oob_shadow");
    check("err_sticky", WV'(addrErr), WV'(1'b1));

    // simultaneous write and commit in IDLE
    address = 4'd2; dataIn = 8'd5; write = 1'b1;
    tick();
    exp_sh[2*DW +: DW] = 8'd5;
    dataIn = 8'd9; commit = 1'b1;
    tick();
    write = 1'b0; commit = 1'b0;
    exp_act = exp_sh;
    exp_sh[2*DW +: DW] = 8'd9;
    check("wc_weight2", WV'(weightsOut[2*DW +: DW]), WV'(8'd5));
    check("wc_active", weightsOut, exp_act);
    rdAddr = 4'd2;
    tick();
    check("wc_shadow2", WV'(rdData), WV'(8'd9));
    commit = 1'b1;
    tick();
    commit = 1'b0;
    exp_act = exp_sh;
    check("wc_second", weightsOut, exp_act);

    // asynchronous reset after three burst accepts
    start_burst(0);
    for (int k = 0; k < 3; k++) send_word(DW'(8'hD0 + k), k);
    rst_n = 1'b0;
    #1;
    exp_sh = '0; exp_act = '0;
    check("arst_weights", weightsOut, '0);
    check("arst_flags", WV'({busy, burstReady, burstDone, addrErr}), '0);
    check("arst_rd", WV'(rdData), '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("arst_no_done", WV'(done_cnt), WV'(2));
    start_burst(3);
    for (int k = 0; k < NW; k++) send_word(DW'(8'hC0 + k), (3 + k) % NW);
    check("rb_done", WV'(burstDone), WV'(1'b1));
    tick();
    check("rb_no_commit", weightsOut, '0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    exp_act = exp_sh;
    check("rb_commit", weightsOut, exp_act);
    check("rb_done_cnt", WV'(done_cnt), WV'(3));
    readback_all("rb_shadow");

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/weight_bank_dbuf.md
Name: weight_bank_dbuf

Overview:
- Parametrised, double-buffered successor to the neuron weight register bank.
- Weights are loaded into a shadow bank, either by single addressed writes or by an auto-incrementing burst with valid/ready handshake.
- Weights go live atomically into the active bank on commit, so the neuron datapath never sees a half-updated weight set.
- Shadow readback port and sticky address-error flag support load verification.

Parameters:
DATA_W, 8, bit width of one weight
N_WEIGHTS, 10, number of weights per bank (≥2, ≤2**ADDR_W)
ADDR_W, 4, address width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
dataIn  in  DATA_W  write data for single write and burst
address  in  ADDR_W  single-write address; burst start address when burstStart=1
write  in  1  single write strobe to shadow bank
burstStart  in  1  start burst load at address
burstValid  in  1  burst word valid on dataIn
burstReady  out  1  bank accepts burst word
burstDone  out  1  one-cycle pulse: burst complete
commit  in  1  copy shadow bank to active bank
rdAddr  in  ADDR_W  shadow readback address
rdData  out  DATA_W  shadow readback data, registered
weightsOut  out  N_WEIGHTS*DATA_W  active bank, weight i at bits [i*DATA_W +: DATA_W]
busy  out  1  burst in progress
addrErr  out  1  sticky out-of-range address flag

Behaviour:
- Reset: async assert clears shadow, active, rdData, addrErr, the pending-commit flag, the burst pointer, and the counter. State=IDLE. burstReady=0, burstDone=0, busy=0, weightsOut=0. Reset mid-burst aborts it; no burstDone pulse.
- FSM states are IDLE, BURST, DONE.
- IDLE:
  - write=1 with address<N_WEIGHTS: shadow[address]<=dataIn at the edge.
  - write=1 with address≥N_WEIGHTS: no write; addrErr<=1.
  - burstStart=1 with address<N_WEIGHTS: ptr<=address, cnt<=0, go BURST. A same-cycle write is ignored.
  - burstStart=1 with address≥N_WEIGHTS: addrErr<=1, stay IDLE.
  - commit=1: active<=shadow (all words) at the edge. With a same-cycle write, the write lands in shadow and active receives the pre-write shadow value.
- BURST:
  - busy=1, burstReady=1.
  - On burstValid=1: shadow[ptr]<=dataIn; ptr<=(ptr==N_WEIGHTS-1)?0:ptr+1 (wrap); cnt<=cnt+1.
  - burstValid=0 stalls with no change.
  - Exactly N_WEIGHTS words are accepted. The edge accepting word N_WEIGHTS-1 (cnt==N_WEIGHTS-1) moves to DONE.
  - write and burstStart are ignored. addrErr is unaffected.
  - commit=1 sets pending; it does not copy immediately.
- DONE: one cycle; burstDone=1, busy=0, burstReady=0.
  - If pending, or commit=1 this cycle: active<=shadow at the edge leaving DONE, including the last burst word. Pending is cleared.
  - Then IDLE.
  - Inputs other than commit are ignored in DONE.
- Latencies:
  - Single write is visible on rdData 2 edges after the write (write edge, then read register).
  - weightsOut changes 1 edge after commit in IDLE.
- rdData: registered shadow[rdAddr] every cycle in all states. Returns 0 if rdAddr≥N_WEIGHTS (does not set addrErr).
- addrErr clears only on reset.
- Widths are fixed: ptr and cnt are ADDR_W bits. No arithmetic is applied to data.

Test Plan:
- Single writes then commit: write i→addr i for i=0..9; weightsOut stays 0 until commit; 1 edge after commit, weight i = i. Readback of rdAddr=3 gives 3 with 1-cycle latency.
- Wrapped burst with stalls: burstStart at address=7, send 0xA0..0xA9 with burstValid deasserted every other cycle. Result: shadow[7..9]=A0..A2, shadow[0..6]=A3..A9; burstDone pulses once, 1 cycle after the 10th accept; busy high throughout the burst.
- Commit during burst: commit pulsed after the 4th word. weightsOut stays unchanged until the edge leaving DONE, then equals the full new set including the last word.
- Out of range: write with address=12 gives no shadow change and addrErr=1. burstStart with address=10 gives no burst (busy=0). rdAddr=15 gives rdData=0. addrErr holds until rst_n.
- Simultaneous write+commit in IDLE: shadow[2]=5, then write 9→addr 2 with commit in the same cycle. Result: weight 2 = 5 and shadow[2]=9; a second commit gives weight 2 = 9.
- Reset mid-burst: rst_n low after 3 accepts. All outputs 0 immediately (async); no burstDone; after release, a new burst behaves normally.
